j1_uart_rx_periph: RTL



---
 rtl/j1_uart_rx_periph_pkg.sv | 38 +++
 rtl/j1_uart_rx_periph_sync_fifo.sv | 75 +++++++
 rtl/j1_uart_rx_periph.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/j1_uart_rx_periph_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : j1_uart_rx_periph_pkg
//  Description : Shared constants and types for the J1 UART receive peripheral
//                (register map, status bit positions, oversampling constants,
//                receiver FSM state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package j1_uart_rx_periph_pkg;

  // Register offsets on the peripheral read port
  localparam logic RX_DATA   = 1'b0;
  localparam logic RX_STATUS = 1'b1;

  // Status register bit positions
  localparam int AVAIL = 0;
  localparam int OVR   = 1;
  localparam int FERR  = 2;

  // Oversampling: ticks per bit and the tick count of the start-bit midpoint
  localparam int OVERSAMPLE = 16;
  localparam int MID_BIT    = 8;

  // Last tick index within a full bit and within the half start bit
  localparam logic [3:0] TICK_LAST_FULL = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_LAST_MID  = 4'(MID_BIT - 1);

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage : j1_uart_rx_periph_pkg
`default_nettype wire

// File: rtl/j1_uart_rx_periph_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : j1_uart_rx_periph_sync_fifo
//  Description : Single-clock FIFO with first-word-fall-through head output.
//                A pop is evaluated before a push, so a simultaneous pop and
//                push on a full FIFO both succeed. A push that cannot be
//                accepted is dropped and flagged on drop_o for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module j1_uart_rx_periph_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_w;
  logic             pop_w;
  logic             push_w;

  assign empty_o = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign pop_w   = pop_i & ~empty_o;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push_w  = push_i & (~full_w | pop_w);
  assign drop_o  = push_i & ~push_w;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy next-state: unchanged when push and pop both take effect
  always_comb begin
    count_d = count_q;
    if (push_w && !pop_w) begin
      count_d = count_q + CW'(1);
    end else if (!push_w && pop_w) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_w)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy guards reads
  always_ff @(posedge clk_i) begin
    if (push_w) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule : j1_uart_rx_periph_sync_fifo
`default_nettype wire

// File: rtl/j1_uart_rx_periph.sv
`default_nettype none
// ============================================================================
//  Module      : j1_uart_rx_periph
//  Description : 8N1 UART receiver for the J1 SoC I/O bus. 16x oversampling,
//                mid-bit start validation, byte FIFO, data/status registers
//                on the peripheral read port and a data-available flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module j1_uart_rx_periph
  import j1_uart_rx_periph_pkg::*;
#(
  parameter int DIVISOR    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        uart_rx_i,
  input  logic        cs_i,
  input  logic        rd_i,
  input  logic        addr_i,
  output logic [15:0] d_out,
  output logic        rx_avail_o
);

  localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Synchronizer, tick generator
  logic             sync1_q;
  logic             sync2_q;
  logic [DIV_W-1:0] div_q;
  logic             tick_w;

  // Receiver FSM
  rx_state_e        state_q;
  logic [3:0]       tcnt_q;
  logic [2:0]       bidx_q;
  logic [7:0]       shift_q;
  logic             push_q;
  logic             ferr_evt_q;

  // FIFO interface
  logic [7:0]       head_w;
  logic             empty_w;
  logic [CNT_W-1:0] count_w;
  logic             drop_w;

  // Register port
  logic             rd_w;
  logic             data_rd_w;
  logic             stat_rd_w;
  logic             ovr_q;
  logic             ovr_d;
  logic             ferr_q;
  logic             ferr_d;
  logic [15:0]      status_w;
  logic [15:0]      d_out_q;

  // Two-flop synchronizer for the asynchronous serial input, idles high
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
    end
  end

  assign tick_w = (div_q == DIV_W'(DIVISOR - 1));

  // Free-running oversample divider producing a one-cycle tick at wrap
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      div_q <= '0;
    end else if (tick_w) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Receiver FSM: start validation, LSB-first data shift, stop check
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      bidx_q     <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      ferr_evt_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_evt_q <= 1'b0;
      if (tick_w) begin
        case (state_q)
          ST_IDLE: begin
            if (!sync2_q) begin
              state_q <= ST_START;
              tcnt_q  <= '0;
            end
          end
          ST_START: begin
            if (tcnt_q == TICK_LAST_MID) begin
              tcnt_q <= '0;
              bidx_q <= '0;
              // A high line at mid start bit was a glitch
              state_q <= sync2_q ? ST_IDLE : ST_DATA;
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end
          ST_DATA: begin
            if (tcnt_q == TICK_LAST_FULL) begin
              tcnt_q  <= '0;
              shift_q <= {sync2_q, shift_q[7:1]};
              bidx_q  <= bidx_q + 3'd1;
              if (bidx_q == 3'd7) state_q <= ST_STOP;
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end
          ST_STOP: begin
            if (tcnt_q == TICK_LAST_FULL) begin
              tcnt_q <= '0;
              if (sync2_q) begin
                push_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                ferr_evt_q <= 1'b1;
                state_q    <= ST_WAIT_HIGH;
              end
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end
          ST_WAIT_HIGH: begin
            // Hold off through a break so it yields a single frame error
            if (sync2_q) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_w      = cs_i & rd_i;
  assign data_rd_w = rd_w & (addr_i == RX_DATA);
  assign stat_rd_w = rd_w & (addr_i == RX_STATUS);

  j1_uart_rx_periph_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (data_rd_w),
    .rdata_o (head_w),
    .empty_o (empty_w),
    .count_o (count_w),
    .drop_o  (drop_w)
  );

  assign rx_avail_o = (count_w != '0);

  // Status word and sticky flags; a new error event beats a same-cycle clear
  always_comb begin
    status_w        = '0;
    status_w[AVAIL] = rx_avail_o;
    status_w[OVR]   = ovr_q;
    status_w[FERR]  = ferr_q;
    ovr_d           = (ovr_q  & ~stat_rd_w) | drop_w;
    ferr_d          = (ferr_q & ~stat_rd_w) | ferr_evt_q;
  end

  // Sticky error flags and registered read data
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      d_out_q <= '0;
    end else begin
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      if (data_rd_w) begin
        d_out_q <= empty_w ? 16'h0000 : {8'h00, head_w};
      end else if (stat_rd_w) begin
        d_out_q <= status_w;
      end
    end
  end

  assign d_out = d_out_q;

endmodule : j1_uart_rx_periph
`default_nettype wire
